// File: rtl/pool_fmap_reader.sv
// Streams pooled feature maps out of pool RAM port B, map by map, row-major, with row/map/frame tags.
// Optional ReLU at the FIFO output when POOL_RD_RELU_EN is defined.
module pool_fmap_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int MAP_W           = 12,
  parameter int MAP_H           = 12,
  parameter int NUM_MAPS        = 4,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      q_b,
  output logic                       rden_b,
  output logic [POOL_ADDR_WIDTH-1:0] address_b,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_eol,
  output logic                       out_eom,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int TOTAL = NUM_MAPS * MAP_W * MAP_H;
  localparam int CW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int RW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int MW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam logic [POOL_ADDR_WIDTH-1:0] LAST_ADDR = POOL_ADDR_WIDTH'(TOTAL - 1);

  generate
    if (TOTAL > (1 << POOL_ADDR_WIDTH)) begin : g_size_check
      $error("pool_fmap_reader: maps do not fit in the pool RAM address space");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_lat_check
      $error("pool_fmap_reader: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [POOL_ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [MW-1:0] map;
  logic [2:0]    fifo_count;
  logic [1:0]    inflight;
  logic [1:0]    wr_ptr, rd_ptr;
  logic          credit_ok, issue, push, pop, accept, final_hs;
  logic [2:0]    issue_tag, head_tag;
  logic [DATA_WIDTH-1:0] head;

  logic                  pipe_v   [RD_LATENCY];
  logic [2:0]            pipe_tag [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [2:0]            fifo_tag  [4];

  // Credits cover both buffered and in-flight reads so a stalled consumer never overflows the FIFO.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight}) < 4'd4;
  assign issue     = rden_b;
  assign accept    = (state == IDLE) && start;
  assign push      = pipe_v[RD_LATENCY-1];
  assign out_valid = (fifo_count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign head      = fifo_data[rd_ptr];
  assign head_tag  = fifo_tag[rd_ptr];
  assign final_hs  = (state == DRAIN) && pop && head_tag[0] && (fifo_count == 3'd1) && (inflight == 2'd0);

  assign issue_tag[2] = (col == CW'(MAP_W - 1));
  assign issue_tag[1] = issue_tag[2] && (row == RW'(MAP_H - 1));
  assign issue_tag[0] = issue_tag[1] && (map == MW'(NUM_MAPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (issue && (addr == LAST_ADDR)) state_nxt = DRAIN;
      DRAIN:   if (final_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rden_b = 1'b0;
    busy   = 1'b0;
    case (state)
      READ: begin
        busy   = 1'b1;
        rden_b = credit_ok;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
      map  <= '0;
    end else if (accept) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
      map  <= '0;
    end else if (issue) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + POOL_ADDR_WIDTH'(1);
      if (issue_tag[2]) begin
        col <= '0;
        if (issue_tag[1]) begin
          row <= '0;
          map <= issue_tag[0] ? '0 : map + MW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign address_b = addr;

  // Tags travel alongside the read so they meet q_b at the FIFO input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= 3'b000;
      end
    end else begin
      pipe_v[0]   <= issue;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 2'd0;
      fifo_count <= 3'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      done       <= 1'b0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: ;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      done <= final_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= q_b;
      fifo_tag[wr_ptr]  <= pipe_tag[RD_LATENCY-1];
    end
  end

`ifdef POOL_RD_RELU_EN
  assign out_data = (out_valid && !head[DATA_WIDTH-1]) ? head : '0;
`else
  assign out_data = out_valid ? head : '0;
`endif
  assign out_eol  = out_valid && head_tag[2];
  assign out_eom  = out_valid && head_tag[1];
  assign out_last = out_valid && head_tag[0];

endmodule
